// File: rtl/stump_bus_responder.sv
// Memory/IO responder for the Stump CPU bus: word RAM, free-running timer and
// a byte output FIFO drained over a valid/ready stream.
module stump_bus_responder #(
  parameter int          RAM_ADDR_BITS = 12,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] IO_BASE       = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_wr,
  output logic [15:0] data_rd,
  input  logic        mem_ren,
  input  logic        mem_wen,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      TIMER_ADDR  = IO_BASE;
  localparam logic [15:0]      TX_ADDR     = IO_BASE + 16'd1;
  localparam logic [15:0]      STATUS_ADDR = IO_BASE + 16'd2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TIMER,
    SEL_TX,
    SEL_STATUS
  } sel_e;

  sel_e             sel;
  logic             rd_en;
  logic             wr_en;
  logic [15:0]      timer;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic             push_drop;
  logic             ovf_clear;
  logic [15:0]      status;

  logic [15:0] ram      [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  // The bus is dead while reset is held: neither strobe has any effect.
  assign rd_en = mem_ren && !rst;
  assign wr_en = mem_wen && !rst;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if (address[15:RAM_ADDR_BITS] == '0)  sel = SEL_RAM;
    else if (address == TIMER_ADDR)       sel = SEL_TIMER;
    else if (address == TX_ADDR)          sel = SEL_TX;
    else if (address == STATUS_ADDR)      sel = SEL_STATUS;
  end

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign out_valid = !empty;
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_req  = wr_en && (sel == SEL_TX);
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && !push_ok;
  assign ovf_clear = wr_en && (sel == SEL_STATUS) && data_wr[2];

  assign status = {8'h00, count, 1'b0, ovf, full, empty};

  always_comb begin
    data_rd = 16'h0000;
    if (rd_en) begin
      unique case (sel)
        SEL_RAM:    data_rd = ram[address[RAM_ADDR_BITS-1:0]];
        SEL_TIMER:  data_rd = timer;
        SEL_STATUS: data_rd = status;
        default:    data_rd = 16'h0000;
      endcase
    end
  end

  // NOTE: storage arrays have no reset branch; clearing them would turn the
  // RAM into thousands of flops, and their contents survive rst by design.
  always_ff @(posedge clk) begin
    if (wr_en && (sel == SEL_RAM)) ram[address[RAM_ADDR_BITS-1:0]] <= data_wr;
    if (push_ok)                   fifo_mem[wr_ptr] <= data_wr[7:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer  <= 16'h0000;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en && (sel == SEL_TIMER)) timer <= data_wr;
      else                             timer <= timer + 16'd1;

      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);

      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A dropped byte outranks a clear arriving in the same cycle.
      if (push_drop)      ovf <= 1'b1;
      else if (ovf_clear) ovf <= 1'b0;
    end
  end

endmodule
